// File: rtl/lcd_spi_byte_tx.sv
// ---------------------------------------------------------------------------
// lcd_spi_byte_tx
//
// Physical-layer stage that sits between the electric-piano LCD controller
// and an ST7789-class panel. It sequences the panel hardware reset, then
// accepts command/data bytes over a valid/ready handshake and shifts each one
// out MSB-first on a 4-wire SPI bus (mode 0: SCLK idles low, data is sampled
// by the panel on the rising edge).
//
// Ports:
//   clk          in   system clock (50 MHz)
//   rst_n        in   asynchronous, active-low reset
//   in_valid     in   a byte is offered
//   in_data[7:0] in   byte to send
//   in_dc        in   0 = command, 1 = data; captured together with in_data
//   in_ready     out  a byte offered this cycle will be taken
//   hw_reset_req in   one-cycle request to rerun the panel reset sequence
//   init_done    out  reset sequence finished, bus usable
//   lcd_sclk     out  SPI clock, idle low
//   lcd_mosi     out  SPI data
//   lcd_cs       out  chip select, active low
//   lcd_dc       out  data/command select
//   lcd_rst      out  panel reset, active low
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module lcd_spi_byte_tx #(
    parameter int CLK_DIV      = 2,
    parameter int RST_LOW_CYC  = 500000,
    parameter int RST_WAIT_CYC = 6000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    output logic       in_ready,
    input  logic       hw_reset_req,
    output logic       init_done,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_cs,
    output logic       lcd_dc,
    output logic       lcd_rst
);

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } state_t;

    // Terminal counts: every timed phase runs its counter from 0 up to these.
    localparam logic [31:0] DIV_LAST      = 32'(CLK_DIV - 1);
    localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0] RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic        pending_q;
    logic        in_ready_q;
    logic        init_done_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_q;
    logic        dc_q;
    logic        rst_q;

    logic        accept_d;
    logic        phase_done_d;
    logic        pend_now_d;
    logic        busy_d;
    logic [31:0] cnt_inc_d;

    // in_ready_q is only ever high in IDLE or HOLD, so a handshake can only
    // occur in those two states.
    assign accept_d     = in_valid & in_ready_q;
    assign phase_done_d = (cnt_q == DIV_LAST);
    // A reset request arriving this very cycle must be honoured just like one
    // that was already pending.
    assign pend_now_d   = pending_q | hw_reset_req;
    assign busy_d       = (state_q == SETUP) || (state_q == SHIFT_HI) ||
                          (state_q == SHIFT_LO) || (state_q == HOLD);
    assign cnt_inc_d    = cnt_q + 32'd1;

    // Whole controller in one sequential block. Outputs are registered
    // alongside the state so each output changes on the same edge as the
    // state transition that implies it. The byte register holds only the
    // seven bits still to be shifted; bit 7 goes straight onto MOSI at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_LOW;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pending_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            dc_q        <= 1'b0;
            rst_q       <= 1'b0;
        end else if (accept_d) begin
            // Accept from IDLE or HOLD; from HOLD cs is already low so the
            // new byte continues the same CS frame.
            state_q    <= SETUP;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= in_data[6:0];
            mosi_q     <= in_data[7];
            dc_q       <= in_dc;
            cs_q       <= 1'b0;
            sclk_q     <= 1'b0;
            in_ready_q <= 1'b0;
            if (hw_reset_req) begin
                pending_q <= 1'b1;
            end
        end else begin
            if (hw_reset_req && busy_d) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                RST_LOW: begin
                    if (cnt_q == RST_LOW_LAST) begin
                        state_q <= RST_WAIT;
                        cnt_q   <= '0;
                        rst_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                RST_WAIT: begin
                    if (cnt_q == RST_WAIT_LAST) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                IDLE: begin
                    if (pend_now_d) begin
                        state_q     <= RST_LOW;
                        cnt_q       <= '0;
                        rst_q       <= 1'b0;
                        init_done_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        pending_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (phase_done_d) begin
                        state_q <= SHIFT_HI;
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                SHIFT_HI: begin
                    if (phase_done_d) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q    <= HOLD;
                            in_ready_q <= !pend_now_d;
                        end else begin
                            // Next bit appears on the same edge SCLK falls.
                            state_q   <= SHIFT_LO;
                            mosi_q    <= shift_q[6];
                            shift_q   <= {shift_q[5:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                SHIFT_LO: begin
                    if (phase_done_d) begin
                        state_q <= SHIFT_HI;
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                HOLD: begin
                    if (hw_reset_req) begin
                        in_ready_q <= 1'b0;
                    end
                    if (phase_done_d) begin
                        // Frame ends; a pending reset drops init_done now and
                        // IDLE launches the reset on the next edge.
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        cs_q       <= 1'b1;
                        in_ready_q <= !pend_now_d;
                        if (pend_now_d) begin
                            init_done_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q     <= RST_LOW;
                    cnt_q       <= '0;
                    rst_q       <= 1'b0;
                    cs_q        <= 1'b1;
                    sclk_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;
    assign lcd_sclk  = sclk_q;
    assign lcd_mosi  = mosi_q;
    assign lcd_cs    = cs_q;
    assign lcd_dc    = dc_q;
    assign lcd_rst   = rst_q;

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_byte_tx
//
// Self-checking bench for lcd_spi_byte_tx with small timing parameters.
// A passive monitor records what the panel would see: the {dc, mosi} pair on
// every SCLK rising edge and the length of every CS-low frame. Each test task
// builds the expected byte/dc list and frame lengths from the protocol rules
// and compares them against the monitor record.
// ---------------------------------------------------------------------------
module tb_lcd_spi_byte_tx;

    localparam int CLK_DIV      = 2;
    localparam int RST_LOW_CYC  = 4;
    localparam int RST_WAIT_CYC = 6;
    localparam int BYTE_CS_CYC  = 17 * CLK_DIV;
    // A byte followed by an accept on the first HOLD cycle occupies
    // setup + 8 high + 7 low phases plus that single HOLD cycle.
    localparam int CHAINED_CYC  = 16 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_dc = 1'b0;
    logic       hw_reset_req = 1'b0;
    logic       in_ready;
    logic       init_done;
    logic       lcd_sclk;
    logic       lcd_mosi;
    logic       lcd_cs;
    logic       lcd_dc;
    logic       lcd_rst;

    int testsRun = 0;
    int testsFailed = 0;

    lcd_spi_byte_tx #(
        .CLK_DIV      (CLK_DIV),
        .RST_LOW_CYC  (RST_LOW_CYC),
        .RST_WAIT_CYC (RST_WAIT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_dc        (in_dc),
        .in_ready     (in_ready),
        .hw_reset_req (hw_reset_req),
        .init_done    (init_done),
        .lcd_sclk     (lcd_sclk),
        .lcd_mosi     (lcd_mosi),
        .lcd_cs       (lcd_cs),
        .lcd_dc       (lcd_dc),
        .lcd_rst      (lcd_rst)
    );

    always #5 clk = ~clk;

    // Panel-side view of the bus, sampled on the falling clk edge.
    logic       prevSclk = 1'b0;
    logic       prevDc = 1'b0;
    int         csLowLen = 0;
    int         dcHighChanges = 0;
    logic [1:0] capBits[$];
    int         csRuns[$];

    always @(negedge clk) begin
        if (lcd_sclk === 1'b1 && prevSclk !== 1'b1) begin
            capBits.push_back({lcd_dc, lcd_mosi});
        end
        if (lcd_sclk === 1'b1 && prevSclk === 1'b1 && lcd_dc !== prevDc) begin
            dcHighChanges++;
        end
        if (lcd_cs === 1'b0) begin
            csLowLen++;
        end else if (csLowLen != 0) begin
            csRuns.push_back(csLowLen);
            csLowLen = 0;
        end
        prevSclk = lcd_sclk;
        prevDc   = lcd_dc;
    end

    // Rebuilds captured byte k as {dc varied within byte, dc, data}.
    function automatic logic [9:0] capWord(int k);
        logic [7:0] b;
        logic       dc0;
        logic       varied;
        b      = 8'h00;
        dc0    = capBits[8 * k][1];
        varied = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], capBits[8 * k + i][0]};
            if (capBits[8 * k + i][1] !== dc0) varied = 1'b1;
        end
        return {varied, dc0, b};
    endfunction

    // Offer a byte at a falling edge and return once it has been taken.
    task automatic applyStimulus(input logic [7:0] b, input logic dc, input bit keepValid);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        in_dc    = dc;
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_data = 8'($urandom);
        in_dc   = 1'($urandom);
        if (!keepValid) in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!(lcd_cs === 1'b1 && in_ready === 1'b1 && init_done === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (n >= 400) begin
            testsFailed++;
            $display("[TB] FAIL idle_timeout: cs=%b ready=%b init=%b, required 1 1 1", lcd_cs, in_ready, init_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        int m;
        int csBad;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({lcd_rst, lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, in_ready, init_done} !== 7'b0100000) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: rst,cs,sclk,mosi,dc,ready,init=%b, required 0100000",
                     {lcd_rst, lcd_cs, lcd_sclk, lcd_mosi, lcd_dc, in_ready, init_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        csBad = 0;
        do begin
            @(negedge clk);
            n++;
            if (lcd_cs !== 1'b1) csBad++;
        end while (lcd_rst !== 1'b1 && n < 50);
        testsRun++;
        if (n !== RST_LOW_CYC) begin
            testsFailed++;
            $display("[TB] FAIL rst_low_len: %0d cycles, required %0d", n, RST_LOW_CYC);
        end
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (lcd_cs !== 1'b1) csBad++;
        end while (init_done !== 1'b1 && m < 50);
        testsRun++;
        if (m !== RST_WAIT_CYC) begin
            testsFailed++;
            $display("[TB] FAIL rst_wait_len: %0d cycles, required %0d", m, RST_WAIT_CYC);
        end
        testsRun++;
        if (in_ready !== 1'b1 || lcd_rst !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_init: ready=%b rst=%b, required 1 1", in_ready, lcd_rst);
        end
        testsRun++;
        if (csBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL cs_during_reset: %0d low samples, required 0", csBad);
        end
    endtask

    task automatic test_single_byte();
        capBits.delete();
        csRuns.delete();
        applyStimulus(8'h2C, 1'b0, 1'b0);
        waitIdle();
        testsRun++;
        if (csRuns.size() != 1 || csRuns[0] != BYTE_CS_CYC) begin
            testsFailed++;
            $display("[TB] FAIL single_cs_len: %0d frames first %0d, required 1 frame of %0d",
                     csRuns.size(), (csRuns.size() > 0) ? csRuns[0] : 0, BYTE_CS_CYC);
        end
        testsRun++;
        if (capBits.size() != 8) begin
            testsFailed++;
            $display("[TB] FAIL single_edges: %0d rising edges, required 8", capBits.size());
        end else begin
            testsRun++;
            if (capWord(0) !== {1'b0, 1'b0, 8'h2C}) begin
                testsFailed++;
                $display("[TB] FAIL single_data: got %h, required %h", capWord(0), {1'b0, 1'b0, 8'h2C});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expWords[2];
        expWords[0] = {1'b0, 1'b1, 8'hA5};
        expWords[1] = {1'b0, 1'b1, 8'h0F};
        capBits.delete();
        csRuns.delete();
        applyStimulus(8'hA5, 1'b1, 1'b1);
        applyStimulus(8'h0F, 1'b1, 1'b0);
        waitIdle();
        testsRun++;
        if (csRuns.size() != 1 || csRuns[0] != CHAINED_CYC + BYTE_CS_CYC) begin
            testsFailed++;
            $display("[TB] FAIL b2b_cs_frame: %0d frames first %0d, required 1 frame of %0d",
                     csRuns.size(), (csRuns.size() > 0) ? csRuns[0] : 0, CHAINED_CYC + BYTE_CS_CYC);
        end
        testsRun++;
        if (capBits.size() != 16) begin
            testsFailed++;
            $display("[TB] FAIL b2b_edges: %0d rising edges, required 16", capBits.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (capWord(k) !== expWords[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_data%0d: got %h, required %h", k, capWord(k), expWords[k]);
                end
            end
        end
    endtask

    task automatic test_dc_switch();
        int hiBefore;
        logic [9:0] expWords[2];
        expWords[0] = {1'b0, 1'b0, 8'h11};
        expWords[1] = {1'b0, 1'b1, 8'h80};
        hiBefore = dcHighChanges;
        capBits.delete();
        csRuns.delete();
        applyStimulus(8'h11, 1'b0, 1'b1);
        applyStimulus(8'h80, 1'b1, 1'b0);
        waitIdle();
        testsRun++;
        if (csRuns.size() != 1) begin
            testsFailed++;
            $display("[TB] FAIL dc_frames: %0d CS frames, required 1", csRuns.size());
        end
        testsRun++;
        if (dcHighChanges != hiBefore) begin
            testsFailed++;
            $display("[TB] FAIL dc_while_sclk_high: %0d changes, required 0", dcHighChanges - hiBefore);
        end
        testsRun++;
        if (capBits.size() != 16) begin
            testsFailed++;
            $display("[TB] FAIL dc_edges: %0d rising edges, required 16", capBits.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                testsRun++;
                if (capWord(k) !== expWords[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL dc_data%0d: got %h, required %h", k, capWord(k), expWords[k]);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        logic [9:0] expWords[$];
        int         expRuns[$];
        int         nb;
        logic [7:0] b;
        logic       d;
        capBits.delete();
        csRuns.delete();
        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 3);
            expRuns.push_back(CHAINED_CYC * (nb - 1) + BYTE_CS_CYC);
            for (int j = 0; j < nb; j++) begin
                b = 8'($urandom);
                d = 1'($urandom);
                expWords.push_back({1'b0, d, b});
                applyStimulus(b, d, j < nb - 1);
            end
            waitIdle();
        end
        testsRun++;
        if (csRuns.size() != expRuns.size()) begin
            testsFailed++;
            $display("[TB] FAIL rand_frames: %0d CS frames, required %0d", csRuns.size(), expRuns.size());
        end else begin
            for (int f = 0; f < expRuns.size(); f++) begin
                testsRun++;
                if (csRuns[f] != expRuns[f]) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_cs_len%0d: %0d cycles, required %0d", f, csRuns[f], expRuns[f]);
                end
            end
        end
        testsRun++;
        if (capBits.size() != 8 * expWords.size()) begin
            testsFailed++;
            $display("[TB] FAIL rand_edges: %0d rising edges, required %0d", capBits.size(), 8 * expWords.size());
        end else begin
            for (int k = 0; k < expWords.size(); k++) begin
                testsRun++;
                if (capWord(k) !== expWords[k]) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_data%0d: got %h, required %h", k, capWord(k), expWords[k]);
                end
            end
        end
    endtask

    task automatic test_hw_reset_mid();
        logic [7:0] b;
        logic       d;
        int         n;
        int         lowN;
        int         earlyReady;
        int         edgesAtInit;
        b = 8'($urandom);
        d = 1'($urandom);
        capBits.delete();
        csRuns.delete();
        applyStimulus(b, d, 1'b1);
        in_data = 8'h5A;
        in_dc   = 1'b1;
        repeat (9) @(negedge clk);
        hw_reset_req = 1'b1;
        @(negedge clk);
        hw_reset_req = 1'b0;
        n = 0;
        while (lcd_cs !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (lcd_cs !== 1'b1 || init_done !== 1'b0 || in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hwreq_frame_end: cs=%b init=%b ready=%b, required 1 0 0", lcd_cs, init_done, in_ready);
        end
        n = 0;
        while (lcd_rst === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lowN = 0;
        earlyReady = 0;
        while (lcd_rst === 1'b0 && lowN < 50) begin
            if (in_ready === 1'b1) earlyReady++;
            lowN++;
            @(negedge clk);
        end
        testsRun++;
        if (lowN != RST_LOW_CYC) begin
            testsFailed++;
            $display("[TB] FAIL hwreq_rst_low: %0d cycles, required %0d", lowN, RST_LOW_CYC);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 50) begin
            if (in_ready === 1'b1 || lcd_cs !== 1'b1) earlyReady++;
            @(negedge clk);
            n++;
        end
        edgesAtInit = capBits.size();
        testsRun++;
        if (earlyReady != 0 || n >= 50) begin
            testsFailed++;
            $display("[TB] FAIL hwreq_blocked: %0d early ready/cs samples, init wait %0d, required 0 and <50", earlyReady, n);
        end
        testsRun++;
        if (edgesAtInit != 8) begin
            testsFailed++;
            $display("[TB] FAIL hwreq_edges_before_init: %0d, required 8", edgesAtInit);
        end
        applyStimulus(8'h5A, 1'b1, 1'b0);
        waitIdle();
        testsRun++;
        if (capBits.size() != 16 || csRuns.size() != 2) begin
            testsFailed++;
            $display("[TB] FAIL hwreq_totals: %0d edges %0d frames, required 16 and 2", capBits.size(), csRuns.size());
        end else begin
            testsRun++;
            if (capWord(0) !== {1'b0, d, b} || capWord(1) !== {1'b0, 1'b1, 8'h5A}) begin
                testsFailed++;
                $display("[TB] FAIL hwreq_data: got %h %h, required %h %h",
                         capWord(0), capWord(1), {1'b0, d, b}, {1'b0, 1'b1, 8'h5A});
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        logic [7:0] b;
        logic       d;
        capBits.delete();
        csRuns.delete();
        applyStimulus(8'($urandom), 1'($urandom), 1'b0);
        n = 0;
        while (capBits.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({lcd_cs, lcd_sclk, lcd_rst, in_ready, init_done} !== 5'b10000) begin
            testsFailed++;
            $display("[TB] FAIL midbyte_reset: cs,sclk,rst,ready,init=%b, required 10000",
                     {lcd_cs, lcd_sclk, lcd_rst, in_ready, init_done});
        end
        @(negedge clk);
        test_reset();
        capBits.delete();
        csRuns.delete();
        b = 8'($urandom);
        d = 1'($urandom);
        applyStimulus(b, d, 1'b0);
        waitIdle();
        testsRun++;
        if (capBits.size() != 8 || csRuns.size() != 1 || csRuns[0] != BYTE_CS_CYC) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_frame: %0d edges %0d frames, required 8 and 1 of %0d",
                     capBits.size(), csRuns.size(), BYTE_CS_CYC);
        end else begin
            testsRun++;
            if (capWord(0) !== {1'b0, d, b}) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_data: got %h, required %h", capWord(0), {1'b0, d, b});
            end
        end
    endtask

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_dc_switch();
        test_random_frames();
        test_hw_reset_mid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lcd_spi_byte_tx.md
Name: lcd_spi_byte_tx

Overview:
- Physical-layer stage directly downstream of the electric-piano LCD controller.
- Accepts command/data bytes tagged with a D/C flag over a valid/ready handshake.
- Serialises each byte MSB-first on a 4-wire SPI bus (mode 0) toward the ST7789-class panel.
- Owns the panel hardware-reset pulse sequence and blocks traffic until that sequence completes.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk cycles, >=1; 2 gives 12.5 MHz from 50 MHz.
- RST_LOW_CYC, 500000: clk cycles lcd_rst is held low (10 ms).
- RST_WAIT_CYC, 6000000: clk cycles after lcd_rst rises before the first byte is accepted (120 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte available.
- in_data  in  8  byte to send.
- in_dc  in  1  0 = command, 1 = data; sampled with in_data.
- in_ready  out  1  block can accept a byte this cycle.
- hw_reset_req  in  1  single-cycle pulse requesting a re-run of the panel reset sequence.
- init_done  out  1  reset sequence complete; bus usable.
- lcd_sclk  out  1  SPI clock, idle low.
- lcd_mosi  out  1  SPI data.
- lcd_cs  out  1  chip select, active low.
- lcd_dc  out  1  data/command select.
- lcd_rst  out  1  panel reset, active low.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All outputs are registered.
- Reset values: lcd_rst=0, lcd_cs=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, in_ready=0, init_done=0, state=RST_LOW, counters=0, pending-reset flag=0.
- States: RST_LOW, RST_WAIT, IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD.
- RST_LOW: lcd_rst=0 for RST_LOW_CYC cycles, then go to RST_WAIT.
- RST_WAIT: lcd_rst=1 for RST_WAIT_CYC cycles, then go to IDLE and set init_done=1.
- IDLE: lcd_cs=1, lcd_sclk=0, in_ready=1.
  - in_valid & in_ready: latch in_data and in_dc, in_ready=0 next cycle, go to SETUP.
- SETUP (CLK_DIV cycles): lcd_cs=0, lcd_dc=latched dc, lcd_mosi=bit7, lcd_sclk=0.
- SHIFT_HI (CLK_DIV cycles): lcd_sclk=1, mosi stable.
  - If the current bit is bit0, go to HOLD.
  - Otherwise go to SHIFT_LO, presenting the next bit on mosi on the same edge sclk falls.
- SHIFT_LO (CLK_DIV cycles): lcd_sclk=0, then return to SHIFT_HI.
- HOLD (CLK_DIV cycles): lcd_sclk=0, lcd_cs=0, in_ready=1.
  - Accept in HOLD: keep cs low, latch the new byte, go to SETUP (back-to-back bytes share one CS frame).
  - HOLD expires with no accept: lcd_cs=1 and go to IDLE.
- Single-byte timing: lcd_cs is low for exactly 17*CLK_DIV cycles (setup + 8 high phases + 7 low phases + hold).
- lcd_dc changes only in SETUP, never while sclk is high. Each byte gets its own dc even within one CS frame.
- Byte and dc are captured only on the accept cycle; changes to in_data/in_dc while not ready are ignored.
- hw_reset_req:
  - In IDLE: next state is RST_LOW, init_done=0, in_ready=0.
  - In any other state: set the pending flag, finish the current byte, go to IDLE with cs=1 (HOLD does not accept new bytes while pending), then perform the reset.
  - In RST_LOW or RST_WAIT: ignored.
- rst_n asserted mid-byte: outputs take reset values immediately; the partial byte is dropped; the sequence restarts from RST_LOW.
- Counters are 32-bit with no wrap within the parameter ranges. in_valid held high with no accept produces no side effect.

Test Plan:
Benches override parameters to CLK_DIV=2, RST_LOW_CYC=4, RST_WAIT_CYC=6.
- Release rst_n -> lcd_rst low for 4 cycles, then high; init_done and in_ready rise 6 cycles later; cs stays 1 throughout.
- Send 0x2C with dc=0 -> cs low for 34 cycles; 8 sclk rising edges; mosi sampled on rising edges reads 0,0,1,0,1,1,0,0; dc=0; cs returns to 1.
- Send 0xA5 (dc=1) then 0x0F (dc=1) back-to-back, valid in HOLD -> cs never deasserts; 16 rising edges; sampled bits read 10100101 00001111.
- Send 0x11 (dc=0) then 0x80 (dc=1) within one CS frame -> dc switches only while sclk=0 in SETUP of the second byte.
- Pulse hw_reset_req mid-byte -> byte completes intact; cs=1; init_done=0; lcd_rst low 4 cycles; no accept until init_done=1 again.
- Assert rst_n low at bit 3 of a byte -> next cycle cs=1, sclk=0, lcd_rst=0, in_ready=0; full reset sequence reruns after release.
